// File: rtl/uart_core.sv
// Full-duplex UART core: 5..8 data bits, 1/2 stop bits, 16x-oversampled receiver with glitch rejection.
// Define UART_PARITY_EN to add a parity bit (even, or odd when PARITY_ODD=1).
module uart_core #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic       PAR_ODD   = 1'(PARITY_ODD);

  logic [DIV_WIDTH-1:0] div_m1;
  assign div_m1 = (baud_div == '0) ? '0 : baud_div - 1'b1;

  // ---------------- transmitter ----------------
  state_t               tx_state, tx_state_n;
  logic [DIV_WIDTH-1:0] tx_cnt;
  logic [3:0]           tx_sub;
  logic [2:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_tick, tx_end, tx_go;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_go   = tx_valid && tx_ready;
  assign tx_tick = (tx_cnt >= div_m1);
  assign tx_end  = tx_tick && (tx_sub == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= IDLE;
    else        tx_state <= tx_state_n;
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_ready   = 1'b0;
    tx         = 1'b1;
    case (tx_state)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) tx_state_n = START;
      end
      START: begin
        tx = 1'b0;
        if (tx_end) tx_state_n = DATA;
      end
      DATA: begin
        tx = tx_shift[0];
        if (tx_end && tx_bit == LAST_DATA)
`ifdef UART_PARITY_EN
          tx_state_n = PARITY;
`else
          tx_state_n = STOP;
`endif
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        tx = tx_par;
        if (tx_end) tx_state_n = STOP;
      end
`endif
      STOP: begin
        if (tx_end && tx_bit == LAST_STOP) tx_state_n = IDLE;
      end
      default: tx_state_n = IDLE;
    endcase
  end

  // Prescaler and counters idle at zero so a new frame starts on a fresh bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt <= '0;
      tx_sub <= '0;
      tx_bit <= '0;
    end else if (tx_state == IDLE) begin
      tx_cnt <= '0;
      tx_sub <= '0;
      tx_bit <= '0;
    end else if (tx_tick) begin
      tx_cnt <= '0;
      tx_sub <= tx_sub + 4'd1;
      if (tx_end) tx_bit <= (tx_state_n != tx_state) ? 3'd0 : tx_bit + 3'd1;
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_go)                          tx_shift <= tx_data;
    else if (tx_state == DATA && tx_end) tx_shift <= tx_shift >> 1;
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (tx_go) tx_par <= (^tx_data) ^ PAR_ODD;
  end
`endif

  // ---------------- receiver ----------------
  state_t               rx_state, rx_state_n;
  logic [1:0]           rx_sync;
  logic                 rx_s;
  logic [DIV_WIDTH-1:0] rx_cnt;
  logic [3:0]           rx_sub;
  logic [2:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_tick, rx_half, rx_mid, rx_done, rx_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], rx};
  end
  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rx_cnt <= '0;
    else if (rx_tick) rx_cnt <= '0;
    else              rx_cnt <= rx_cnt + 1'b1;
  end

  assign rx_tick = (rx_cnt >= div_m1);
  assign rx_half = rx_tick && (rx_sub == 4'd7);
  assign rx_mid  = rx_tick && (rx_sub == 4'd15);
  assign rx_hs   = rx_valid && rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= IDLE;
    else        rx_state <= rx_state_n;
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_done    = 1'b0;
    case (rx_state)
      IDLE:  if (!rx_s) rx_state_n = START;
      // A line that is high again at mid start bit was a glitch.
      START: if (rx_half) rx_state_n = rx_s ? IDLE : DATA;
      DATA: begin
        if (rx_mid && rx_bit == LAST_DATA)
`ifdef UART_PARITY_EN
          rx_state_n = PARITY;
`else
          rx_state_n = STOP;
`endif
      end
`ifdef UART_PARITY_EN
      PARITY: if (rx_mid) rx_state_n = STOP;
`endif
      STOP: begin
        if (rx_mid) begin
          rx_done    = 1'b1;
          rx_state_n = IDLE;
        end
      end
      default: rx_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sub <= '0;
      rx_bit <= '0;
    end else if (rx_state_n != rx_state) begin
      rx_sub <= '0;
      rx_bit <= '0;
    end else if (rx_tick) begin
      rx_sub <= rx_sub + 4'd1;
      if (rx_mid) rx_bit <= rx_bit + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_state == DATA && rx_mid) rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
  end

`ifdef UART_PARITY_EN
  logic rx_par_bit;
  always_ff @(posedge clk) begin
    if (rx_state == PARITY && rx_mid) rx_par_bit <= rx_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           rx_parity_err <= 1'b0;
    else if (rx_done && (!rx_valid || rx_hs)) rx_parity_err <= (^rx_shift) ^ rx_par_bit ^ PAR_ODD;
  end
`else
  // PARITY_ODD has no effect without parity; the AND keeps the flag constant 0.
  assign rx_parity_err = 1'b0 & PAR_ODD;
`endif

  // A completed byte lands only if the holding register is free or being emptied now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      if (rx_done && (!rx_valid || rx_hs)) begin
        rx_data      <= rx_shift;
        rx_frame_err <= !rx_s;
        rx_valid     <= 1'b1;
      end else if (rx_hs) begin
        rx_valid <= 1'b0;
      end
      if (rx_done && rx_valid && !rx_hs) rx_overrun <= 1'b1;
      else if (rx_hs)                    rx_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: an 8-data/1-stop instance (loopback or driven rx)
// and a 5-data/2-stop instance with its own reset.
`timescale 1ns/1ps
module tb_uart_core;
`ifdef UART_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        rst_n, rst5_n;
  logic [15:0] div;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, tx_line;
  logic        rx_line, rx_drv, loop;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready, rx_fe, rx_pe, rx_ov;
  assign rx_line = loop ? tx_line : rx_drv;

  uart_core u8 (
    .clk(clk), .rst_n(rst_n), .baud_div(div),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx_line),
    .rx(rx_line), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_frame_err(rx_fe), .rx_parity_err(rx_pe), .rx_overrun(rx_ov)
  );

  logic [4:0] tx5_data, rx5_data;
  logic       tx5_valid, tx5_ready, tx5_line;
  logic       rx5_valid, rx5_ready, rx5_fe, rx5_pe, rx5_ov;

  uart_core #(.DATA_BITS(5), .STOP_BITS(2)) u5 (
    .clk(clk), .rst_n(rst5_n), .baud_div(div),
    .tx_data(tx5_data), .tx_valid(tx5_valid), .tx_ready(tx5_ready), .tx(tx5_line),
    .rx(tx5_line), .rx_data(rx5_data), .rx_valid(rx5_valid), .rx_ready(rx5_ready),
    .rx_frame_err(rx5_fe), .rx_parity_err(rx5_pe), .rx_overrun(rx5_ov)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    logic       ov;
  } rec_t;
  rec_t got_q[$];

  always @(posedge clk)
    if (rst_n && rx_valid && rx_ready) got_q.push_back({rx_data, rx_fe, rx_pe, rx_ov});

  // Reference model: bit idx of a frame on the wire.
  function automatic int nbits(int d, int s);
    return 1 + d + PBITS + s;
  endfunction

  function automatic logic wire_bit(logic [7:0] v, int d, int idx);
    int ones;
    if (idx == 0) return 1'b0;
    if (idx <= d) return v[idx-1];
    if (PBITS == 1 && idx == d + 1) begin
      ones = 0;
      for (int i = 0; i < d; i++) ones += int'(v[i]);
      return (ones % 2) == 1;   // even parity bit
    end
    return 1'b1;
  endfunction

  function automatic int eff_div();
    return (div == 16'd0) ? 1 : int'(div);
  endfunction

  task automatic send_tx8(input logic [7:0] v);
    int dv, nb, low, w, idx;
    dv = eff_div();
    nb = nbits(8, 1);
    w = 0;
    while (!tx_ready && w < 5000) begin @(negedge clk); w++; end
    tx_data  = v;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    low = 0;
    for (int c = 1; c <= 20*16*dv + 4; c++) begin
      if (tx_ready) break;
      low++;
      if (c >= 8*dv && (c - 8*dv) % (16*dv) == 0) begin
        idx = (c - 8*dv) / (16*dv);
        if (idx < nb) begin
          checks++;
          if (tx_line !== wire_bit(v, 8, idx)) begin
            failures++;
            $display("FAIL tx_bit byte=%0h idx=%0d: got %b expected %b", v, idx, tx_line, wire_bit(v, 8, idx));
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (low !== nb*16*dv) begin
      failures++;
      $display("FAIL tx_ready_low byte=%0h: got %0d cycles expected %0d", v, low, nb*16*dv);
    end
  endtask

  task automatic drive_rx8(input logic [7:0] v, input bit bad_stop, input bit flip_par);
    int dv, nb;
    logic b;
    dv = eff_div();
    nb = nbits(8, 1);
    for (int idx = 0; idx < nb; idx++) begin
      b = wire_bit(v, 8, idx);
      if (PBITS == 1 && idx == 9 && flip_par) b = ~b;
      if (idx == 9 + PBITS && bad_stop) begin
        rx_drv = 1'b0;
        repeat (10*dv) @(negedge clk);
        rx_drv = 1'b1;
        repeat (6*dv) @(negedge clk);
      end else begin
        rx_drv = b;
        repeat (16*dv) @(negedge clk);
      end
    end
    rx_drv = 1'b1;
    repeat (32*dv) @(negedge clk);
  endtask

  task automatic rx_accept();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst5_n = 1'b0;
    div = 16'd4; loop = 1'b1; rx_drv = 1'b1; rx_ready = 1'b0;
    tx_data = '0; tx_valid = 1'b0; tx5_data = '0; tx5_valid = 1'b0; rx5_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_line, tx_ready, rx_valid, rx_fe, rx_pe, rx_ov} !== 6'b110000) begin
      failures++;
      $display("FAIL reset_ctrl8: got %b expected 110000", {tx_line, tx_ready, rx_valid, rx_fe, rx_pe, rx_ov});
    end
    checks++;
    if (rx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data8: got %0h expected 0", rx_data);
    end
    checks++;
    if ({tx5_line, tx5_ready, rx5_valid, rx5_fe, rx5_pe, rx5_ov, rx5_data} !== {6'b110000, 5'd0}) begin
      failures++;
      $display("FAIL reset_u5: got %b expected 11000000000", {tx5_line, tx5_ready, rx5_valid, rx5_fe, rx5_pe, rx5_ov, rx5_data});
    end
    rst_n = 1'b1; rst5_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_loopback_a5();
    div = 16'd4; loop = 1'b1; rx_ready = 1'b0;
    got_q.delete();
    send_tx8(8'hA5);
    checks++;
    if ({rx_valid, rx_data, rx_fe, rx_pe, rx_ov} !== {1'b1, 8'hA5, 3'b000}) begin
      failures++;
      $display("FAIL loopback_a5: got v=%b d=%0h f=%b%b%b expected v=1 d=a5 f=000", rx_valid, rx_data, rx_fe, rx_pe, rx_ov);
    end
    rx_accept();
    checks++;
    if (rx_valid !== 1'b0 || got_q.size() != 1) begin
      failures++;
      $display("FAIL loopback_accept: got valid=%b count=%0d expected valid=0 count=1", rx_valid, got_q.size());
    end
  endtask

  task automatic test_random_loopback();
    logic [7:0] v;
    loop = 1'b1; rx_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      div = (n == 0) ? 16'd0 : 16'($urandom_range(1, 5));
      v = 8'($urandom);
      got_q.delete();
      send_tx8(v);
      repeat (2) @(negedge clk);
      checks++;
      if (got_q.size() != 1 || got_q[0] !== {v, 3'b000}) begin
        failures++;
        $display("FAIL random_loopback div=%0d: got count=%0d rec=%0h expected rec=%0h", div, got_q.size(),
                 (got_q.size() > 0) ? got_q[0] : 11'h0, {v, 3'b000});
      end
    end
    rx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] b0, b1;
    int low;
    div = 16'd2; loop = 1'b1; rx_ready = 1'b1;
    b0 = 8'($urandom); b1 = 8'($urandom);
    got_q.delete();
    tx_data = b0; tx_valid = 1'b1;
    @(negedge clk);
    tx_data = b1;
    low = 0;
    while (!tx_ready && low < 2000) begin low++; @(negedge clk); end
    checks++;
    if (low != nbits(8, 1)*16*2) begin
      failures++;
      $display("FAIL b2b_len: got %0d expected %0d", low, nbits(8, 1)*16*2);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    checks++;
    if ({tx_ready, tx_line} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_gap: got ready,tx=%b expected 00", {tx_ready, tx_line});
    end
    low = 0;
    while (!tx_ready && low < 2000) begin low++; @(negedge clk); end
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() != 2 || got_q[0].d !== b0 || got_q[1].d !== b1) begin
      failures++;
      $display("FAIL b2b_rx: got count=%0d expected 2 bytes %0h %0h", got_q.size(), b0, b1);
    end
    rx_ready = 1'b0;
  endtask

  task automatic test_frame_err();
    div = 16'd3; loop = 1'b0; rx_ready = 1'b0;
    drive_rx8(8'h5A, 1'b1, 1'b0);
    checks++;
    if ({rx_valid, rx_data, rx_fe, rx_ov} !== {1'b1, 8'h5A, 2'b10}) begin
      failures++;
      $display("FAIL frame_err_bad: got v=%b d=%0h fe=%b ov=%b expected v=1 d=5a fe=1 ov=0", rx_valid, rx_data, rx_fe, rx_ov);
    end
    rx_accept();
    drive_rx8(8'hC3, 1'b0, 1'b0);
    checks++;
    if ({rx_valid, rx_data, rx_fe, rx_ov} !== {1'b1, 8'hC3, 2'b00}) begin
      failures++;
      $display("FAIL frame_err_clean: got v=%b d=%0h fe=%b ov=%b expected v=1 d=c3 fe=0 ov=0", rx_valid, rx_data, rx_fe, rx_ov);
    end
    rx_accept();
  endtask

  task automatic test_overrun();
    div = 16'd3; loop = 1'b0; rx_ready = 1'b0;
    got_q.delete();
    drive_rx8(8'h11, 1'b0, 1'b0);
    drive_rx8(8'h22, 1'b0, 1'b0);
    checks++;
    if ({rx_valid, rx_data, rx_ov} !== {1'b1, 8'h11, 1'b1}) begin
      failures++;
      $display("FAIL overrun_hold: got v=%b d=%0h ov=%b expected v=1 d=11 ov=1", rx_valid, rx_data, rx_ov);
    end
    rx_accept();
    checks++;
    if ({rx_valid, rx_ov} !== 2'b00) begin
      failures++;
      $display("FAIL overrun_clear: got v,ov=%b expected 00", {rx_valid, rx_ov});
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {8'h11, 3'b001}) begin
      failures++;
      $display("FAIL overrun_rec: got count=%0d expected one rec=%0h", got_q.size(), {8'h11, 3'b001});
    end
  endtask

  task automatic test_glitch();
    int seen;
    div = 16'd4; loop = 1'b0; rx_ready = 1'b0;
    rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
    seen = 0;
    repeat (4*64) begin @(negedge clk); if (rx_valid) seen++; end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL glitch_no_valid: got %0d valid cycles expected 0", seen);
    end
    drive_rx8(8'h3C, 1'b0, 1'b0);
    checks++;
    if ({rx_valid, rx_data, rx_fe} !== {1'b1, 8'h3C, 1'b0}) begin
      failures++;
      $display("FAIL glitch_next_frame: got v=%b d=%0h fe=%b expected v=1 d=3c fe=0", rx_valid, rx_data, rx_fe);
    end
    rx_accept();
  endtask

  task automatic test_random_rx();
    rec_t exp_q[$];
    logic [7:0] v;
    bit bad;
    div = 16'd3; loop = 1'b0; rx_ready = 1'b1;
    got_q.delete();
    for (int n = 0; n < 8; n++) begin
      v = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      exp_q.push_back({v, bad, 1'b0, 1'b0});
      drive_rx8(v, bad, 1'b0);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL random_rx_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL random_rx[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]);
      end
    end
    rx_ready = 1'b0;
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    div = 16'd2; loop = 1'b1; rx_ready = 1'b0;
    send_tx8(8'h07);
    checks++;
    if ({rx_valid, rx_data, rx_pe} !== {1'b1, 8'h07, 1'b0}) begin
      failures++;
      $display("FAIL parity_good: got v=%b d=%0h pe=%b expected v=1 d=07 pe=0", rx_valid, rx_data, rx_pe);
    end
    rx_accept();
    loop = 1'b0;
    drive_rx8(8'h07, 1'b0, 1'b1);
    checks++;
    if ({rx_valid, rx_data, rx_pe} !== {1'b1, 8'h07, 1'b1}) begin
      failures++;
      $display("FAIL parity_flip: got v=%b d=%0h pe=%b expected v=1 d=07 pe=1", rx_valid, rx_data, rx_pe);
    end
    rx_accept();
  endtask
`endif

  task automatic test_small_cfg();
    int dv, nb, low, w, idx;
    logic [7:0] v;
    div = 16'd2; dv = 2; nb = nbits(5, 2);
    tx5_data = 5'h1F; tx5_valid = 1'b1;
    @(negedge clk);
    tx5_valid = 1'b0;
    repeat (16*dv*3) @(negedge clk);
    checks++;
    if (tx5_ready !== 1'b0) begin
      failures++;
      $display("FAIL small_busy: got ready=%b expected 0", tx5_ready);
    end
    rst5_n = 1'b0;
    #1;
    checks++;
    if ({tx5_line, tx5_ready, rx5_valid} !== 3'b110) begin
      failures++;
      $display("FAIL small_async_reset: got %b expected 110", {tx5_line, tx5_ready, rx5_valid});
    end
    @(negedge clk);
    rst5_n = 1'b1;
    repeat (2) @(negedge clk);
    v = 8'h0A;
    tx5_data = 5'h0A; tx5_valid = 1'b1;
    @(negedge clk);
    tx5_valid = 1'b0;
    low = 0;
    for (int c = 1; c <= 20*16*dv; c++) begin
      if (tx5_ready) break;
      low++;
      if (c >= 8*dv && (c - 8*dv) % (16*dv) == 0) begin
        idx = (c - 8*dv) / (16*dv);
        if (idx < nb) begin
          checks++;
          if (tx5_line !== wire_bit(v, 5, idx)) begin
            failures++;
            $display("FAIL small_tx_bit idx=%0d: got %b expected %b", idx, tx5_line, wire_bit(v, 5, idx));
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (low != nb*16*dv) begin
      failures++;
      $display("FAIL small_len: got %0d expected %0d", low, nb*16*dv);
    end
    checks++;
    if ({rx5_valid, rx5_data, rx5_fe} !== {1'b1, 5'h0A, 1'b0}) begin
      failures++;
      $display("FAIL small_rx: got v=%b d=%0h fe=%b expected v=1 d=0a fe=0", rx5_valid, rx5_data, rx5_fe);
    end
    // Reset during a start bit, where the line is low.
    tx5_data = 5'h00; tx5_valid = 1'b1;
    w = 0;
    while (!tx5_ready && w < 100) begin @(negedge clk); w++; end
    @(negedge clk);
    tx5_valid = 1'b0;
    repeat (8*dv) @(negedge clk);
    checks++;
    if (tx5_line !== 1'b0) begin
      failures++;
      $display("FAIL small_start_low: got %b expected 0", tx5_line);
    end
    rst5_n = 1'b0;
    #1;
    checks++;
    if ({tx5_line, tx5_ready, rx5_valid, rx5_data} !== {3'b110, 5'd0}) begin
      failures++;
      $display("FAIL small_reset_start: got %b expected 11000000", {tx5_line, tx5_ready, rx5_valid, rx5_data});
    end
    @(negedge clk);
    rst5_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loopback_a5();
    test_random_loopback();
    test_back_to_back();
    test_frame_err();
    test_overrun();
    test_glitch();
    test_random_rx();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    test_small_cfg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
